// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel counters, sync decode and a blanked, registered RGB stage for the DAC pins.
// Optional macro VGA_TEST_PATTERN_EN adds an 8-bar colour pattern selected by test_mode.
module vga_sync_gen #(
   parameter int H_VISIBLE = 800,
   parameter int H_FRONT   = 56,
   parameter int H_SYNC    = 120,
   parameter int H_BACK    = 64,
   parameter int V_VISIBLE = 600,
   parameter int V_FRONT   = 37,
   parameter int V_SYNC    = 6,
   parameter int V_BACK    = 23,
   parameter bit HSYNC_POL = 1'b1,
   parameter bit VSYNC_POL = 1'b1,
   parameter int CLK_DIV   = 1
) (
   input  logic        uclk,
   input  logic        reset,
   input  logic [2:0]  R_in,
   input  logic [2:0]  G_in,
   input  logic [1:0]  B_in,
   input  logic        test_mode,
   output logic [10:0] PixelX,
   output logic [10:0] PixelY,
   output logic        hsync,
   output logic        vsync,
   output logic        video_on,
   output logic [2:0]  VgaR,
   output logic [2:0]  VgaG,
   output logic [1:0]  VgaB,
   output logic        frame_tick
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT    = 11'(H_VISIBLE);
   localparam logic [10:0] V_ACT    = 11'(V_VISIBLE);
   localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic        pix_en;
   logic [10:0] h_cnt_p0;
   logic [10:0] v_cnt_p0;
   logic        act_p0;
   logic        hs_p0;
   logic        vs_p0;
   logic [7:0]  rgb_p0;

   function automatic logic [7:0] blank_rgb(input logic act, input logic [7:0] rgb);
      return act ? rgb : 8'd0;
   endfunction

   function automatic logic sync_level(input logic active, input bit pol);
      return active ? pol : ~pol;
   endfunction

   generate
      if (CLK_DIV == 1) begin : g_nodiv
         assign pix_en = 1'b1;
      end else begin : g_div
         logic [3:0] div;
         always_ff @(posedge uclk or posedge reset) begin
            if (reset)
               div <= '0;
            else if (div == 4'(CLK_DIV - 1))
               div <= '0;
            else
               div <= div + 4'd1;
         end
         assign pix_en = (div == 4'(CLK_DIV - 1));
      end
   endgenerate

   // Stage p0: raster counters, presented to the game logic with zero latency
   always_ff @(posedge uclk or posedge reset) begin
      if (reset) begin
         h_cnt_p0 <= '0;
         v_cnt_p0 <= '0;
      end else if (pix_en) begin
         if (h_cnt_p0 == H_LAST) begin
            h_cnt_p0 <= '0;
            v_cnt_p0 <= (v_cnt_p0 == V_LAST) ? 11'd0 : v_cnt_p0 + 11'd1;
         end else begin
            h_cnt_p0 <= h_cnt_p0 + 11'd1;
         end
      end
   end

   assign PixelX = h_cnt_p0;
   assign PixelY = v_cnt_p0;

   assign act_p0 = (h_cnt_p0 < H_ACT) && (v_cnt_p0 < V_ACT);
   assign hs_p0  = (h_cnt_p0 >= HS_START) && (h_cnt_p0 <= HS_END);
   assign vs_p0  = (v_cnt_p0 >= VS_START) && (v_cnt_p0 <= VS_END);

`ifdef VGA_TEST_PATTERN_EN
   localparam int BAR_W = H_VISIBLE / 8;

   // Bar index from a compare chain; the smallest matching boundary wins.
   function automatic logic [7:0] bar_rgb(input logic [10:0] x);
      logic [2:0] k;
      k = 3'd7;
      for (int i = 6; i >= 0; i--)
         if (x < 11'((i + 1) * BAR_W)) k = 3'(i);
      return {{3{k[2]}}, {3{k[1]}}, {2{k[0]}}};
   endfunction

   assign rgb_p0 = test_mode ? bar_rgb(h_cnt_p0) : {R_in, G_in, B_in};
`else
   logic unused_test_mode;
   assign unused_test_mode = test_mode;
   assign rgb_p0 = {R_in, G_in, B_in};
`endif

   // Stage p1: pin register, one pixel behind PixelX/PixelY
   always_ff @(posedge uclk or posedge reset) begin
      if (reset) begin
         hsync      <= ~HSYNC_POL;
         vsync      <= ~VSYNC_POL;
         video_on   <= 1'b0;
         VgaR       <= '0;
         VgaG       <= '0;
         VgaB       <= '0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= pix_en && (h_cnt_p0 == H_LAST) && (v_cnt_p0 == V_LAST);
         if (pix_en) begin
            hsync              <= sync_level(hs_p0, HSYNC_POL);
            vsync              <= sync_level(vs_p0, VSYNC_POL);
            video_on           <= act_p0;
            {VgaR, VgaG, VgaB} <= blank_rgb(act_p0, rgb_p0);
         end
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: two reduced-timing instances (pixel every cycle, and divide-by-3 with
// inverted hsync) compared every cycle against a pixel-index arithmetic model.
module tb_vga_sync_gen;

   localparam int HV = 16, HF = 2, HS = 3, HB = 3;
   localparam int VV = 8, VF = 1, VS = 2, VB = 1;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FRAME = HT * VT;
   localparam int DIV0 = 1, DIV1 = 3;
   localparam bit HPOL0 = 1'b1, VPOL0 = 1'b1, HPOL1 = 1'b0, VPOL1 = 1'b1;
`ifdef VGA_TEST_PATTERN_EN
   localparam bit PAT = 1'b1;
`else
   localparam bit PAT = 1'b0;
`endif

   typedef struct packed {
      logic [10:0] x;
      logic [10:0] y;
      logic        hs;
      logic        vs;
      logic        on;
      logic [2:0]  r;
      logic [2:0]  g;
      logic [1:0]  b;
      logic        tick;
   } obs_t;

   logic       uclk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] R_in = '0;
   logic [2:0] G_in = '0;
   logic [1:0] B_in = '0;
   logic       test_mode = 1'b0;

   logic [10:0] px [2];
   logic [10:0] py [2];
   logic        hsy [2];
   logic        vsy [2];
   logic        von [2];
   logic [2:0]  vr [2];
   logic [2:0]  vg [2];
   logic [1:0]  vb [2];
   logic        ftk [2];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 uclk = ~uclk;

   vga_sync_gen #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .HSYNC_POL(HPOL0), .VSYNC_POL(VPOL0), .CLK_DIV(DIV0)
   ) dut0 (
      .uclk(uclk), .reset(reset), .R_in(R_in), .G_in(G_in), .B_in(B_in), .test_mode(test_mode),
      .PixelX(px[0]), .PixelY(py[0]), .hsync(hsy[0]), .vsync(vsy[0]), .video_on(von[0]),
      .VgaR(vr[0]), .VgaG(vg[0]), .VgaB(vb[0]), .frame_tick(ftk[0])
   );

   vga_sync_gen #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .HSYNC_POL(HPOL1), .VSYNC_POL(VPOL1), .CLK_DIV(DIV1)
   ) dut1 (
      .uclk(uclk), .reset(reset), .R_in(R_in), .G_in(G_in), .B_in(B_in), .test_mode(test_mode),
      .PixelX(px[1]), .PixelY(py[1]), .hsync(hsy[1]), .vsync(vsy[1]), .video_on(von[1]),
      .VgaR(vr[1]), .VgaG(vg[1]), .VgaB(vb[1]), .frame_tick(ftk[1])
   );

   function automatic int div_of(int d);
      return (d == 0) ? DIV0 : DIV1;
   endfunction

   function automatic bit hpol(int d);
      return (d == 0) ? HPOL0 : HPOL1;
   endfunction

   function automatic bit vpol(int d);
      return (d == 0) ? VPOL0 : VPOL1;
   endfunction

   function automatic obs_t idle_obs(int d);
      obs_t o;
      o = '0;
      o.hs = ~hpol(d);
      o.vs = ~vpol(d);
      return o;
   endfunction

   // Pin values produced for pixel number p (counted from reset release).
   function automatic obs_t pixel_obs(int d, int p, logic [2:0] r, logic [2:0] g, logic [1:0] b,
                                      logic tm);
      obs_t o;
      int   x, y, k;
      o = '0;
      x = p % HT;
      y = (p / HT) % VT;
      o.on = (x < HV) && (y < VV);
      o.hs = ((x >= HV + HF) && (x < HV + HF + HS)) ? hpol(d) : ~hpol(d);
      o.vs = ((y >= VV + VF) && (y < VV + VF + VS)) ? vpol(d) : ~vpol(d);
      if (o.on) begin
         o.r = r;
         o.g = g;
         o.b = b;
         if (tm && PAT) begin
            k = x / (HV / 8);
            o.r = {3{k[2]}};
            o.g = {3{k[1]}};
            o.b = {2{k[0]}};
         end
      end
      o.tick = ((p + 1) % FRAME) == 0;
      return o;
   endfunction

   function automatic obs_t no_tick(obs_t o);
      obs_t t;
      t = o;
      t.tick = 1'b0;
      return t;
   endfunction

   int   cnt [2];
   obs_t reg_exp [2];

   always @(posedge uclk or posedge reset) begin
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            cnt[d]     <= 0;
            reg_exp[d] <= idle_obs(d);
         end else begin
            cnt[d] <= cnt[d] + 1;
            if ((cnt[d] + 1) % div_of(d) == 0)
               reg_exp[d] <= pixel_obs(d, cnt[d] / div_of(d), R_in, G_in, B_in, test_mode);
            else
               reg_exp[d] <= no_tick(reg_exp[d]);
         end
      end
   end

   function automatic obs_t expected(int d);
      obs_t o;
      o = reg_exp[d];
      o.x = 11'((cnt[d] / div_of(d)) % HT);
      o.y = 11'((cnt[d] / div_of(d) / HT) % VT);
      return o;
   endfunction

   function automatic obs_t actual(int d);
      obs_t o;
      o = {px[d], py[d], hsy[d], vsy[d], von[d], vr[d], vg[d], vb[d], ftk[d]};
      return o;
   endfunction

   task automatic drive_random(input bit tm_random);
      R_in      = 3'($urandom);
      G_in      = 3'($urandom);
      B_in      = 2'($urandom);
      test_mode = tm_random ? 1'($urandom) : 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge uclk);
      for (int d = 0; d < 2; d++) begin
         n_cmp++;
         if (actual(d) !== idle_obs(d)) begin
            n_bad++;
            $display("FAIL reset_state dut%0d: got %h required %h", d, actual(d), idle_obs(d));
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_free_run();
      for (int i = 0; i < 1800; i++) begin
         @(negedge uclk);
         for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (actual(d) !== expected(d)) begin
               n_bad++;
               $display("FAIL free_run dut%0d cycle %0d: got %h required %h",
                        d, i, actual(d), expected(d));
            end
         end
         drive_random(1'b1);
      end
   endtask

   task automatic test_timing();
      int hrun [2] = '{-1, -1};
      int vrun [2] = '{-1, -1};
      int since [2] = '{0, 0};
      bit seen [2] = '{1'b0, 1'b0};
      bit prev_tick [2] = '{1'b0, 1'b0};
      for (int i = 0; i < 2 * FRAME * DIV1 + 200; i++) begin
         @(negedge uclk);
         for (int d = 0; d < 2; d++) begin
            if (hsy[d] == hpol(d)) begin
               if (hrun[d] >= 0) hrun[d]++;
            end else begin
               if (hrun[d] > 0) begin
                  n_cmp++;
                  if (hrun[d] != HS * div_of(d)) begin
                     n_bad++;
                     $display("FAIL hsync_width dut%0d: got %0d cycles required %0d",
                              d, hrun[d], HS * div_of(d));
                  end
               end
               hrun[d] = 0;
            end
            if (vsy[d] == vpol(d)) begin
               if (vrun[d] >= 0) vrun[d]++;
            end else begin
               if (vrun[d] > 0) begin
                  n_cmp++;
                  if (vrun[d] != VS * HT * div_of(d)) begin
                     n_bad++;
                     $display("FAIL vsync_width dut%0d: got %0d cycles required %0d",
                              d, vrun[d], VS * HT * div_of(d));
                  end
               end
               vrun[d] = 0;
            end
            since[d]++;
            if (ftk[d]) begin
               n_cmp++;
               if (prev_tick[d]) begin
                  n_bad++;
                  $display("FAIL tick_width dut%0d: got high on consecutive cycles required 1 cycle", d);
               end
               if (seen[d]) begin
                  n_cmp++;
                  if (since[d] != FRAME * div_of(d)) begin
                     n_bad++;
                     $display("FAIL tick_period dut%0d: got %0d cycles required %0d",
                              d, since[d], FRAME * div_of(d));
                  end
               end
               seen[d]  = 1'b1;
               since[d] = 0;
            end
            prev_tick[d] = ftk[d];
         end
         drive_random(1'b1);
      end
      for (int d = 0; d < 2; d++) begin
         n_cmp++;
         if (!seen[d]) begin
            n_bad++;
            $display("FAIL tick_present dut%0d: got no frame_tick required at least one", d);
         end
      end
   endtask

   task automatic test_blanking();
      R_in = 3'd7;
      G_in = 3'd5;
      B_in = 2'd2;
      test_mode = 1'b0;
      for (int i = 0; i < FRAME + 2; i++) begin
         @(negedge uclk);
         for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if ({vr[d], vg[d], vb[d]} !== (von[d] ? 8'({3'd7, 3'd5, 2'd2}) : 8'd0)) begin
               n_bad++;
               $display("FAIL blanking dut%0d cycle %0d: got rgb %h with video_on %b",
                        d, i, {vr[d], vg[d], vb[d]}, von[d]);
            end
            n_cmp++;
            if (actual(d) !== expected(d)) begin
               n_bad++;
               $display("FAIL blank_model dut%0d cycle %0d: got %h required %h",
                        d, i, actual(d), expected(d));
            end
         end
      end
   endtask

   task automatic test_pattern();
      for (int i = 0; i < FRAME * DIV1; i++) begin
         @(negedge uclk);
         for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (actual(d) !== expected(d)) begin
               n_bad++;
               $display("FAIL pattern dut%0d cycle %0d: got %h required %h",
                        d, i, actual(d), expected(d));
            end
         end
         drive_random(1'b0);
         test_mode = 1'b1;
      end
      test_mode = 1'b0;
   endtask

   task automatic test_async_reset();
      int waited = 0;
      while (!(px[0] == 11'(HV / 2) && py[0] == 11'(VV / 2)) && waited < 2 * FRAME) begin
         @(negedge uclk);
         drive_random(1'b1);
         waited++;
      end
      n_cmp++;
      if (waited >= 2 * FRAME) begin
         n_bad++;
         $display("FAIL async_reset_wait: got timeout after %0d cycles required mid-frame position", waited);
      end
      @(posedge uclk);
      #2;
      reset = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         n_cmp++;
         if (actual(d) !== idle_obs(d)) begin
            n_bad++;
            $display("FAIL async_reset_immediate dut%0d: got %h required %h", d, actual(d), idle_obs(d));
         end
      end
      repeat (3) @(negedge uclk);
      for (int d = 0; d < 2; d++) begin
         n_cmp++;
         if (actual(d) !== idle_obs(d)) begin
            n_bad++;
            $display("FAIL async_reset_hold dut%0d: got %h required %h", d, actual(d), idle_obs(d));
         end
      end
      reset = 1'b0;
      for (int i = 0; i < 3 * HT * DIV1; i++) begin
         @(negedge uclk);
         for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (actual(d) !== expected(d)) begin
               n_bad++;
               $display("FAIL restart dut%0d cycle %0d: got %h required %h",
                        d, i, actual(d), expected(d));
            end
         end
         drive_random(1'b1);
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_timing();
      test_blanking();
      test_pattern();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Video timing stage directly upstream of the game-logic/pixel-colour block.
- Generates the PixelX/PixelY raster coordinates that the game logic consumes.
- Takes back the game logic's combinational R/G/B for those coordinates, then blanks and registers them with HSYNC/VSYNC to drive the VGA DAC pins.
- Default timing is 800x600 @ 72 Hz from a 50 MHz uclk; also emits a once-per-frame tick usable for movement timing.

Parameters:
H_VISIBLE, 800, active pixels per line
H_FRONT, 56, horizontal front porch (pixels)
H_SYNC, 120, horizontal sync width (pixels)
H_BACK, 64, horizontal back porch (pixels)
V_VISIBLE, 600, active lines per frame
V_FRONT, 37, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BACK, 23, vertical back porch (lines)
HSYNC_POL, 1, active level of hsync
VSYNC_POL, 1, active level of vsync
CLK_DIV, 1, uclk cycles per pixel (1..16); 1 = pixel every cycle

Ports:
uclk  input  1  system clock; single clock domain
reset  input  1  asynchronous, active-high reset
R_in  input  3  red from game logic for current PixelX/PixelY
G_in  input  3  green from game logic
B_in  input  2  blue from game logic
test_mode  input  1  selects colour-bar pattern (used only with VGA_TEST_PATTERN_EN)
PixelX  output  11  current horizontal count (= h_cnt register)
PixelY  output  11  current vertical count (= v_cnt register)
hsync  output  1  registered horizontal sync
vsync  output  1  registered vertical sync
video_on  output  1  registered active-area flag, aligned with RGB outputs
VgaR  output  3  registered, blanked red
VgaG  output  3  registered, blanked green
VgaB  output  2  registered, blanked blue
frame_tick  output  1  one-uclk pulse at start of each frame

Behaviour:
- Derived totals: H_TOTAL = sum of H_* (1040); V_TOTAL = sum of V_* (666). All counters are 11-bit unsigned.
- Pixel enable (pix_en):
  - CLK_DIV=1: pix_en is constant 1.
  - Otherwise: a div counter runs 0..CLK_DIV-1 and pix_en=1 when div=CLK_DIV-1.
- Counter update, on pix_en only:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0.
  - When h_cnt wraps, v_cnt increments; at V_TOTAL-1 it wraps to 0.
  - Counters hold between enables.
- PixelX=h_cnt and PixelY=v_cnt, driven directly with zero latency. Game-logic RGB is combinational on these.
- Internal decodes from the current counters:
  - act = (h_cnt<H_VISIBLE)&&(v_cnt<V_VISIBLE)
  - hs = h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]
  - vs = v_cnt in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1]
- Output register, updated on pix_en:
  - hsync = hs ? HSYNC_POL : ~HSYNC_POL; vsync likewise with VSYNC_POL.
  - video_on = act.
  - VgaR/G/B = act ? R_in/G_in/B_in : 0.
  - Latency from PixelX/PixelY to pins is exactly 1 pixel, identical for sync, video_on and colour.
- frame_tick:
  - Registered; high for exactly one uclk cycle.
  - Occurs in the cycle after the pix_en on which h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, i.e. coincident with PixelX=PixelY=0.
  - Independent of CLK_DIV (always one uclk wide).
- Reset (async, any time, including mid-line or mid-sync):
  - div, h_cnt and v_cnt go to 0.
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL.
  - video_on=0, VgaR/G/B=0, frame_tick=0.
  - After release, the first pix_en computes outputs for (0,0). No frame_tick is issued for the frame begun by reset.
- Blanking: colour is forced to 0 outside the active area regardless of R_in/G_in/B_in.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined, test_mode=1:
  - R_in/G_in/B_in are ignored.
  - The active area shows 8 vertical bars, each H_VISIBLE/8 (100) pixels wide, bar index k=0..7 from the left.
  - Bar colour: VgaR={3{k[2]}}, VgaG={3{k[1]}}, VgaB={2{k[0]}}.
  - k is derived by compare chain on h_cnt; no divider.
  - Blanking, timing and latency are unchanged.
- Defined, test_mode=0: normal pass-through.
- Not defined: test_mode is ignored and no pattern logic exists.

Test Plan:
1. CLK_DIV=1, release reset at t=0 -> PixelX counts 0..1039 then wraps, PixelY increments at wrap; hsync high from cycle 857 for exactly 120 cycles each line.
2. R_in=7, G_in=5, B_in=2 constant -> VgaR/G/B=7/5/2 for 800 cycles starting one cycle after PixelX=0 on lines 0..599; 0 for the remaining 240 cycles and on lines 600..665.
3. Free run -> vsync high for 6240 cycles starting one cycle after (PixelX=0, PixelY=637); frame_tick pulses one cycle wide every 692640 cycles.
4. Assert reset at PixelX=400, PixelY=300 -> PixelX=PixelY=0, video_on=0, hsync/vsync=0 and RGB=0 immediately, without waiting for a clock edge; after release, counting restarts from 0.
5. CLK_DIV=2 -> PixelX advances every 2 cycles; hsync width 240 cycles; frame_tick period 1385280 cycles, still 1 cycle wide.
6. VGA_TEST_PATTERN_EN defined, test_mode=1 -> PixelX 0..99 gives RGB 0/0/0, 100..199 gives 0/0/3, ..., 700..799 gives 7/7/3; test_mode=0 returns to R_in/G_in/B_in.
